// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_pkg
// Description : AXI4-lite response codes, bridge state encoding and defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DRAIN   = 3'd5
    } bridge_state_t;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;
    localparam int         TMO_CNT_W    = 16;

endpackage
`default_nettype wire

// File: rtl/mem_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_axi_bridge
// Description : Single-outstanding core data port to AXI4-lite manager, with
//               a cycle timeout that releases the core and drains the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_axi_bridge
    import axi4_lite_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 aclk,
    input  logic                 areset,
    // core side
    input  logic                 req,
    input  logic                 we,
    input  logic [WIDTH-1:0]     addr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wstrb,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     rdata,
    output logic                 err,
    output logic                 timeout,
    // AXI4-lite manager
    output logic [WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]           m_axi_awprot,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [WIDTH-1:0]     m_axi_wdata,
    output logic [WIDTH/8-1:0]   m_axi_wstrb,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic [WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]           m_axi_arprot,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready
);

    localparam int                   STRB_W   = WIDTH / 8;
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

    bridge_state_t        state, next_state;
    logic [TMO_CNT_W-1:0] tmo_cnt;
    logic                 aw_pend, w_pend, b_pend, ar_pend, r_pend;
    logic [WIDTH-1:0]     addr_q, wdata_q;
    logic [STRB_W-1:0]    wstrb_q;

    logic accept, tmo_hit, pend_clear;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic fin_ok, fin_err, fin_rd, fin_tmo;

    // Every AXI output is decoded from registers only, so no input reaches an output.
    always_comb begin
        busy          = (state != ST_IDLE);
        m_axi_awaddr  = addr_q;
        m_axi_araddr  = addr_q;
        m_axi_awprot  = PROT_DEFAULT;
        m_axi_arprot  = PROT_DEFAULT;
        m_axi_wdata   = wdata_q;
        m_axi_wstrb   = wstrb_q;
        m_axi_awvalid = aw_pend;
        m_axi_wvalid  = w_pend;
        m_axi_arvalid = ar_pend;
        m_axi_bready  = b_pend & ~aw_pend & ~w_pend;
        m_axi_rready  = r_pend & ~ar_pend;
    end

    assign aw_hs  = m_axi_awvalid & m_axi_awready;
    assign w_hs   = m_axi_wvalid  & m_axi_wready;
    assign b_hs   = m_axi_bready  & m_axi_bvalid;
    assign ar_hs  = m_axi_arvalid & m_axi_arready;
    assign r_hs   = m_axi_rready  & m_axi_rvalid;
    assign accept = (state == ST_IDLE) & req;
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    assign pend_clear = ~(aw_pend & ~aw_hs) & ~(w_pend & ~w_hs) & ~(b_pend & ~b_hs)
                      & ~(ar_pend & ~ar_hs) & ~(r_pend & ~r_hs);

    // A final handshake landing on the timeout cycle takes priority over the timeout.
    always_comb begin
        next_state = state;
        fin_ok     = 1'b0;
        fin_err    = 1'b0;
        fin_rd     = 1'b0;
        fin_tmo    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    next_state = we ? ST_WRITE : ST_RD_ADDR;
                end
            end
            ST_WRITE: begin
                if (tmo_hit) begin
                    fin_tmo    = 1'b1;
                    next_state = ST_DRAIN;
                end else if ((~aw_pend | aw_hs) & (~w_pend | w_hs)) begin
                    next_state = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    fin_ok     = 1'b1;
                    fin_err    = (m_axi_bresp != RESP_OKAY);
                    next_state = ST_IDLE;
                end else if (tmo_hit) begin
                    fin_tmo    = 1'b1;
                    next_state = ST_DRAIN;
                end
            end
            ST_RD_ADDR: begin
                if (tmo_hit) begin
                    fin_tmo    = 1'b1;
                    next_state = ST_DRAIN;
                end else if (ar_hs) begin
                    next_state = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    fin_ok     = 1'b1;
                    fin_rd     = 1'b1;
                    fin_err    = (m_axi_rresp != RESP_OKAY);
                    next_state = ST_IDLE;
                end else if (tmo_hit) begin
                    fin_tmo    = 1'b1;
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pend_clear) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            b_pend  <= 1'b0;
            ar_pend <= 1'b0;
            r_pend  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            timeout <= 1'b0;
            rdata   <= '0;
        end else begin
            state   <= next_state;
            done    <= fin_ok | fin_tmo;
            err     <= fin_err | fin_tmo;
            timeout <= fin_tmo;
            if (fin_tmo) begin
                rdata <= '0;
            end else if (fin_rd) begin
                rdata <= m_axi_rdata;
            end

            if (accept) begin
                tmo_cnt <= '0;
                addr_q  <= addr;
                if (we) begin
                    wdata_q <= wdata;
                    wstrb_q <= wstrb;
                    aw_pend <= 1'b1;
                    w_pend  <= 1'b1;
                    b_pend  <= 1'b1;
                end else begin
                    ar_pend <= 1'b1;
                    r_pend  <= 1'b1;
                end
            end else begin
                if (state != ST_IDLE && state != ST_DRAIN) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
                if (aw_hs) aw_pend <= 1'b0;
                if (w_hs)  w_pend  <= 1'b0;
                if (b_hs)  b_pend  <= 1'b0;
                if (ar_hs) ar_pend <= 1'b0;
                if (r_hs)  r_pend  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_axi_bridge
// Description : Bench for mem_axi_bridge: delay-programmable AXI4-lite
//               subordinate plus a latency/data reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_axi_bridge;

    localparam int          TMO    = 8;
    localparam logic [31:0] RO_VAL = 32'h0000_A5A5;

    logic        aclk   = 1'b0;
    logic        areset = 1'b1;
    logic        req    = 1'b0;
    logic        we     = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [3:0]  wstrb  = '0;
    logic        busy, done, err, timeout;
    logic [31:0] rdata;

    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
    logic        m_axi_awready = 1'b0;
    logic        m_axi_wready  = 1'b0;
    logic        m_axi_bvalid  = 1'b0;
    logic [1:0]  m_axi_bresp   = 2'b00;
    logic        m_axi_arready = 1'b0;
    logic        m_axi_rvalid  = 1'b0;
    logic [1:0]  m_axi_rresp   = 2'b00;
    logic [31:0] m_axi_rdata   = '0;

    int vectors    = 0;
    int miscompares = 0;

    // subordinate delay knobs and state
    int da = 0, dw = 0, db = 0, dar = 0, dr = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_got = 0, w_got = 0, ar_got = 0, mem_init = 0;
    logic bready_prev = 1'b0, rready_prev = 1'b0;
    logic [31:0] cap_aw = '0, cap_w = '0, cap_ar = '0;
    logic [3:0]  cap_s = '0;
    logic [31:0] sub_mem [8];
    logic [31:0] ref_mem [8];

    mem_axi_bridge #(.WIDTH(32), .TIMEOUT(TMO)) dut (
        .aclk(aclk), .areset(areset),
        .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .busy(busy), .done(done), .rdata(rdata), .err(err), .timeout(timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    // Subordinate: drives on the falling edge; a ready/valid raised last
    // falling edge means the handshake completed at the rising edge between.
    always @(negedge aclk) begin
        if (!mem_init) begin
            for (int i = 0; i < 8; i++) sub_mem[i] = 32'(i) * 32'h1111_1111;
            mem_init = 1;
        end
        if (areset) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            bready_prev = 0; rready_prev = 0;
        end else begin
            if (m_axi_awready) begin
                aw_got = 1; m_axi_awready = 0;
            end else if (m_axi_awvalid && !aw_got) begin
                if (aw_cnt >= da) begin m_axi_awready = 1; cap_aw = m_axi_awaddr; end
                else aw_cnt++;
            end
            if (m_axi_wready) begin
                w_got = 1; m_axi_wready = 0;
            end else if (m_axi_wvalid && !w_got) begin
                if (w_cnt >= dw) begin m_axi_wready = 1; cap_w = m_axi_wdata; cap_s = m_axi_wstrb; end
                else w_cnt++;
            end
            if (m_axi_arready) begin
                ar_got = 1; m_axi_arready = 0;
            end else if (m_axi_arvalid && !ar_got) begin
                if (ar_cnt >= dar) begin m_axi_arready = 1; cap_ar = m_axi_araddr; end
                else ar_cnt++;
            end
            if (m_axi_bvalid && bready_prev) begin
                m_axi_bvalid = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else if (aw_got && w_got && !m_axi_bvalid) begin
                if (b_cnt >= db) begin
                    m_axi_bvalid = 1;
                    if (cap_aw[1:0] != 2'b00 || cap_aw[4:2] == 3'd1) begin
                        m_axi_bresp = 2'b10;
                    end else begin
                        m_axi_bresp = 2'b00;
                        for (int b = 0; b < 4; b++)
                            if (cap_s[b]) sub_mem[cap_aw[4:2]][8*b +: 8] = cap_w[8*b +: 8];
                    end
                end else b_cnt++;
            end
            if (m_axi_rvalid && rready_prev) begin
                m_axi_rvalid = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
            end else if (ar_got && !m_axi_rvalid) begin
                if (r_cnt >= dr) begin
                    m_axi_rvalid = 1;
                    if (cap_ar[1:0] != 2'b00) begin m_axi_rresp = 2'b10; m_axi_rdata = '0; end
                    else if (cap_ar[4:2] == 3'd1) begin m_axi_rresp = 2'b00; m_axi_rdata = RO_VAL; end
                    else begin m_axi_rresp = 2'b00; m_axi_rdata = sub_mem[cap_ar[4:2]]; end
                end else r_cnt++;
            end
            bready_prev = m_axi_bready;
            rready_prev = m_axi_rready;
        end
    end

    task automatic set_delays(input int a, input int w, input int b, input int ar, input int r);
        da = a; dw = w; db = b; dar = ar; dr = r;
    endtask

    // One core transaction. Expected completion follows from the subordinate
    // delays: the last handshake lands at cycle h, done one cycle later,
    // unless h exceeds TMO, in which case done is forced at TMO+1.
    task automatic do_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                          input logic [3:0] t_wstrb, input int probe_cyc, output logic [2:0] probe_v);
        int h, d, cyc, idx, pulses;
        logic misal, exp_tmo, exp_err;
        logic [31:0] exp_rd;
        idx     = int'(t_addr[4:2]);
        misal   = (t_addr[1:0] != 2'b00);
        probe_v = 3'b000;
        if (t_we) h = 2 + ((da > dw) ? da : dw) + db;
        else      h = 2 + dar + dr;
        exp_tmo = (h > TMO);
        d       = exp_tmo ? TMO + 1 : h + 1;
        exp_err = exp_tmo || misal || (t_we && idx == 1);
        if (exp_tmo || misal) exp_rd = '0;
        else if (idx == 1)    exp_rd = RO_VAL;
        else                  exp_rd = ref_mem[idx];
        if (t_we && !misal && idx != 1)
            for (int b = 0; b < 4; b++)
                if (t_wstrb[b]) ref_mem[idx][8*b +: 8] = t_wdata[8*b +: 8];

        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; wstrb = t_wstrb;
        @(negedge aclk);
        req = 1'b0;
        cyc = 1;
        vectors++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== (t_we ? 3'b110 : 3'b001)) begin
            miscompares++;
            $display("FAIL issue_valids: got %b expected %b", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid},
                     (t_we ? 3'b110 : 3'b001));
        end
        while (!done && cyc < 64) begin
            if (cyc == probe_cyc) probe_v = {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid};
            @(negedge aclk);
            cyc++;
        end
        if (cyc == probe_cyc) probe_v = {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid};
        vectors++;
        if (cyc != d) begin
            miscompares++;
            $display("FAIL done_cycle: got %0d expected %0d (we=%0b addr=%h)", cyc, d, t_we, t_addr);
        end
        vectors++;
        if (err !== exp_err) begin
            miscompares++;
            $display("FAIL err: got %b expected %b (we=%0b addr=%h)", err, exp_err, t_we, t_addr);
        end
        vectors++;
        if (timeout !== exp_tmo) begin
            miscompares++;
            $display("FAIL timeout_flag: got %b expected %b", timeout, exp_tmo);
        end
        vectors++;
        if (busy !== exp_tmo) begin
            miscompares++;
            $display("FAIL busy_at_done: got %b expected %b", busy, exp_tmo);
        end
        if (!t_we) begin
            vectors++;
            if (rdata !== exp_rd) begin
                miscompares++;
                $display("FAIL rdata: got %h expected %h (addr=%h)", rdata, exp_rd, t_addr);
            end
        end
        if (exp_tmo) begin
            pulses = 0;
            while (busy && cyc < 96) begin
                @(negedge aclk);
                cyc++;
                if (done) pulses++;
                if (cyc == probe_cyc) probe_v = {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid};
            end
            vectors++;
            if (cyc != h + 1) begin
                miscompares++;
                $display("FAIL drain_end: got %0d expected %0d", cyc, h + 1);
            end
            vectors++;
            if (pulses != 0) begin
                miscompares++;
                $display("FAIL extra_done: got %0d expected 0", pulses);
            end
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        vectors++;
        if ({done, err, timeout} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 000", {done, err, timeout});
        end
        vectors++;
        if (rdata !== 32'h0) begin
            miscompares++; $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        vectors++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_axi: got %b expected 00000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready});
        end
        vectors++;
        if ({m_axi_awprot, m_axi_arprot} !== 6'b0) begin
            miscompares++; $display("FAIL prot: got %b expected 000000", {m_axi_awprot, m_axi_arprot});
        end
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_write_gpio();
        logic [2:0] pv;
        set_delays(0, 1, 0, 0, 0);
        do_txn(1'b1, 32'h0, 32'h0000_FFFF, 4'hF, 0, pv);
        vectors++;
        if (cap_aw !== 32'h0) begin
            miscompares++; $display("FAIL gpio_awaddr: got %h expected 0", cap_aw);
        end
        vectors++;
        if (cap_w !== 32'h0000_FFFF) begin
            miscompares++; $display("FAIL gpio_wdata: got %h expected 0000ffff", cap_w);
        end
    endtask

    task automatic test_read_gpio();
        logic [2:0] pv;
        set_delays(0, 0, 0, 0, 0);
        do_txn(1'b0, 32'h4, 32'h0, 4'h0, 0, pv);
        do_txn(1'b0, 32'h0, 32'h0, 4'h0, 0, pv);
    endtask

    task automatic test_w_before_aw();
        logic [2:0] pv;
        set_delays(3, 0, 0, 0, 0);
        do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2, pv);
        vectors++;
        if (pv !== 3'b100) begin
            miscompares++; $display("FAIL w_first_valids: got %b expected 100", pv);
        end
        @(negedge aclk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL w_first_single_done: got %b expected 0", done);
        end
        set_delays(0, 0, 0, 0, 0);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, pv);
    endtask

    task automatic test_slverr();
        logic [2:0] pv;
        set_delays(0, 1, 0, 0, 0);
        do_txn(1'b1, 32'h4, 32'h1234_5678, 4'hF, 0, pv);
    endtask

    task automatic test_timeout();
        logic [2:0] pv;
        set_delays(0, 0, 0, 12, 2);
        do_txn(1'b0, 32'h8, 32'h0, 4'h0, 10, pv);
        vectors++;
        if (pv !== 3'b001) begin
            miscompares++; $display("FAIL drain_arvalid: got %b expected 001", pv);
        end
    endtask

    task automatic test_reset_wr_resp();
        logic [2:0] pv;
        set_delays(0, 0, 5, 0, 0);
        req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        @(negedge aclk);
        req = 1'b0;
        @(negedge aclk);
        vectors++;
        if (m_axi_bready !== 1'b1) begin
            miscompares++; $display("FAIL wr_resp_bready: got %b expected 1", m_axi_bready);
        end
        areset = 1'b1;
        @(negedge aclk);
        vectors++;
        if ({busy, m_axi_bready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready, done} !== 7'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got %b expected 0000000",
                     {busy, m_axi_bready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready, done});
        end
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        set_delays(0, 0, 0, 1, 1);
        do_txn(1'b0, 32'h4, 32'h0, 4'h0, 0, pv);
    endtask

    function automatic int rand_delay();
        return ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
    endfunction

    // Back-to-back: each transaction is issued on the falling edge of the
    // previous done cycle, so acceptance coincides with done.
    task automatic test_back_to_back_random();
        logic [2:0]  pv;
        logic        t_we;
        logic [31:0] t_addr, t_data, r;
        logic [3:0]  t_strb;
        for (int n = 0; n < 60; n++) begin
            set_delays(rand_delay(), rand_delay(), rand_delay(), rand_delay(), rand_delay());
            t_we   = 1'($urandom_range(0, 1));
            r      = $urandom();
            t_addr = (r & 32'hFFFF_FFE0) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 7) == 0) t_addr = t_addr | 32'($urandom_range(1, 3));
            t_data = $urandom();
            t_strb = 4'($urandom_range(0, 15));
            do_txn(t_we, t_addr, t_data, t_strb, 0, pv);
            vectors++;
            if (t_we) begin
                if (cap_aw !== t_addr || cap_w !== t_data || cap_s !== t_strb) begin
                    miscompares++;
                    $display("FAIL write_passthru: got %h/%h/%h expected %h/%h/%h",
                             cap_aw, cap_w, cap_s, t_addr, t_data, t_strb);
                end
            end else begin
                if (cap_ar !== t_addr) begin
                    miscompares++;
                    $display("FAIL read_passthru: got %h expected %h", cap_ar, t_addr);
                end
            end
        end
        set_delays(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) do_txn(1'b0, 32'(i) << 2, 32'h0, 4'h0, 0, pv);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ref_mem[i] = 32'(i) * 32'h1111_1111;
        test_reset();
        test_write_gpio();
        test_read_gpio();
        test_w_before_aw();
        test_slverr();
        test_timeout();
        test_reset_wr_resp();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
